// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, with sign fix-up at the end.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);
    localparam int N  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state;

    logic [N-1:0]  hi, lo, opnd;
    logic [CW-1:0] cnt;
    logic [2:0]    fn;
    logic          neg_a, neg_b;

    logic          is_div, a_signed, b_signed, sa, sb, special;
    logic [N-1:0]  mag_a, mag_b, special_res;

    always_comb begin
        is_div   = funct3[2];
        a_signed = is_div ? !funct3[0] : (funct3[1:0] != 2'b11);
        b_signed = is_div ? !funct3[0] : !funct3[1];
        sa       = a_signed & op_a[N-1];
        sb       = b_signed & op_b[N-1];
        mag_a    = sa ? -op_a : op_a;
        mag_b    = sb ? -op_b : op_b;
        special     = 1'b0;
        special_res = '0;
        if (is_div && op_b == '0) begin
            special     = 1'b1;
            special_res = funct3[1] ? op_a : '1;
        end else if (is_div && !funct3[0] && op_a == {1'b1, {(N-1){1'b0}}} && op_b == '1) begin
            special     = 1'b1;
            special_res = funct3[1] ? '0 : op_a;
        end
    end

    // Divide step: the shifted partial remainder's top bit is hi[N-1]; if set, it
    // certainly exceeds the divisor, so an N-bit subtract is sufficient.
    logic [N:0]   mul_sum;
    logic [N-1:0] div_shift, div_diff;
    logic         div_ge;

    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        div_shift = {hi[N-2:0], lo[N-1]};
        div_ge    = hi[N-1] | (div_shift >= opnd);
        div_diff  = div_shift - opnd;
    end

    logic [2*N-1:0] prod, prod_s;
    logic [N-1:0]   quo_s, rem_s, fix_res;

    always_comb begin
        prod   = {hi, lo};
        prod_s = (neg_a ^ neg_b) ? -prod : prod;
        quo_s  = (neg_a ^ neg_b) ? -lo : lo;
        rem_s  = neg_a ? -hi : hi;
        case (fn)
            3'b000:                 fix_res = prod_s[N-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_s[2*N-1:N];
            3'b100, 3'b101:         fix_res = quo_s;
            default:                fix_res = rem_s;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            hi     <= '0;
            lo     <= '0;
            opnd   <= '0;
            cnt    <= '0;
            fn     <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        fn    <= funct3;
                        neg_a <= sa;
                        neg_b <= sb;
                        if (special) begin
                            result <= special_res;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            busy  <= 1'b1;
                            cnt   <= CW'(N - 1);
                            hi    <= '0;
                            lo    <= is_div ? mag_a : mag_b;
                            opnd  <= is_div ? mag_b : mag_a;
                            state <= CALC;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    if (fn[2]) begin
                        hi <= div_ge ? div_diff : div_shift;
                        lo <= {lo[N-2:0], div_ge};
                    end else begin
                        hi <= mul_sum[N:1];
                        lo <= {mul_sum[0], lo[N-1:1]};
                    end
                    if (cnt == '0) state <= FIX;
                    else           cnt   <= cnt - 1'b1;
                end
                FIX: begin
                    result <= fix_res;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results queued at issue, compared at done.
module tb_muldiv_unit;
    localparam int N = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    funct3 = '0;
    logic [N-1:0]  op_a = '0;
    logic [N-1:0]  op_b = '0;
    logic          busy, done;
    logic [N-1:0]  result;

    int            checks = 0;
    int            failures = 0;
    logic [N-1:0]  exp_q[$];
    logic [N-1:0]  prev_res = '0;

    always #5 clk = ~clk;

    muldiv_unit #(.DATA_WIDTH(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic is_special(input logic [2:0] f, input logic [N-1:0] a, input logic [N-1:0] b);
        return f[2] && (b == '0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [N-1:0] model(input logic [2:0] f, input logic [N-1:0] a, input logic [N-1:0] b);
        longint sa, sb, ub, r;
        longint unsigned pu;
        logic [63:0] w;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = {32'h0, b};
        case (f)
            3'd0: begin r = sa * sb; w = r; return w[31:0]; end
            3'd1: begin r = sa * sb; w = r; return w[63:32]; end
            3'd2: begin r = sa * ub; w = r; return w[63:32]; end
            3'd3: begin pu = {32'h0, a}; pu = pu * {32'h0, b}; w = pu; return w[63:32]; end
            3'd4: begin
                if (b == '0) return '1;
                r = sa / sb; w = r; return w[31:0];
            end
            3'd5: return (b == '0) ? '1 : a / b;
            3'd6: begin
                if (b == '0) return a;
                r = sa % sb; w = r; return w[31:0];
            end
            default: return (b == '0) ? a : a % b;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives start for one cycle from the current cycle; returns in cycle 1.
    task automatic issue(input logic [2:0] f, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] exp);
        exp_q.push_back(exp);
        start  = 1'b1;
        funct3 = f;
        op_a   = a;
        op_b   = b;
        step();
        start  = 1'b0;
        funct3 = 3'($urandom);
        op_a   = $urandom;
        op_b   = $urandom;
    endtask

    // Called in cycle 1; returns in the cycle where done is observed.
    task automatic wait_done(input int exp_lat, input string name);
        int lat;
        logic seen, busy_ok, hold_ok;
        logic [N-1:0] exp;
        lat = 1; seen = 1'b0; busy_ok = 1'b1; hold_ok = 1'b1;
        while (lat <= N + 8) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (result !== prev_res) hold_ok = 1'b0;
            step();
            lat++;
        end
        exp = exp_q.pop_front();
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s timeout: done not seen within %0d cycles", name, N + 8);
        end else begin
            checks++;
            if (lat !== exp_lat) begin
                failures++;
                $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
            end
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL %s busy_with_done: got %b expected 0", name, busy);
            end
            checks++;
            if (!busy_ok) begin
                failures++;
                $display("FAIL %s busy_gap: got busy low before done expected high", name);
            end
            checks++;
            if (!hold_ok) begin
                failures++;
                $display("FAIL %s result_hold: got change before done expected %h held", name, prev_res);
            end
            checks++;
            if (result !== exp) begin
                failures++;
                $display("FAIL %s result: got %h expected %h", name, result, exp);
            end
        end
        prev_res = exp;
    endtask

    task automatic run_op(input logic [2:0] f, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] exp, input string name);
        issue(f, a, b, exp);
        wait_done(is_special(f, a, b) ? 1 : N + 2, name);
        step();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL %s done_pulse: got %b expected 0", name, done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
            failures++;
            $display("FAIL reset_state: got busy=%b done=%b result=%h expected 0 0 0", busy, done, result);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: got busy=%b done=%b expected 0 0", busy, done);
        end
        prev_res = '0;
    endtask

    task automatic test_mul();
        logic [N-1:0] a, b;
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7xm3");
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 3; k++) begin
                a = $urandom;
                b = $urandom;
                run_op(3'(f), a, b, model(3'(f), a, b), "mul_rand");
            end
        end
    endtask

    task automatic test_div();
        logic [N-1:0] a, b;
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2");
        run_op(3'd5, 32'd100, 32'd7, 32'd14, "divu_100_7");
        run_op(3'd7, 32'd100, 32'd7, 32'd2, "remu_100_7");
        for (int f = 4; f < 8; f++) begin
            for (int k = 0; k < 3; k++) begin
                a = $urandom;
                b = (k == 0) ? 32'($urandom_range(1, 15)) : $urandom;
                if (k == 2) b = -b;
                run_op(3'(f), a, b, model(3'(f), a, b), "div_rand");
            end
        end
    endtask

    task automatic test_special();
        run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu_by0");
        run_op(3'd6, 32'd5, 32'd0, 32'd5, "rem_by0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_ovf");
        run_op(3'd4, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, "div_by0");
        run_op(3'd7, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, "remu_by0");
    endtask

    task automatic test_ignore_start();
        int lat, extra;
        logic seen, busy_ok;
        logic [N-1:0] exp;
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        lat = 1; seen = 1'b0; busy_ok = 1'b1;
        while (lat <= N + 8) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            start  = (lat == 5 || lat == 20);
            funct3 = 3'd4;
            op_a   = $urandom;
            op_b   = 32'd0;
            step();
            lat++;
        end
        start = 1'b0;
        exp = exp_q.pop_front();
        prev_res = exp;
        checks++;
        if (!seen || lat != N + 2) begin
            failures++;
            $display("FAIL ignore_latency: got seen=%b cycle %0d expected cycle %0d", seen, lat, N + 2);
        end
        checks++;
        if (!busy_ok) begin
            failures++;
            $display("FAIL ignore_busy: got busy low during op expected high");
        end
        checks++;
        if (result !== exp) begin
            failures++;
            $display("FAIL ignore_result: got %h expected %h", result, exp);
        end
        extra = 0;
        for (int i = 0; i < N + 4; i++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL ignore_queued: got %0d active cycles after done expected 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        issue(3'd5, 32'd100, 32'd7, 32'd14);
        wait_done(N + 2, "b2b_first");
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        wait_done(N + 2, "b2b_second");
        issue(3'd4, 32'd9, 32'd0, 32'hFFFF_FFFF);
        wait_done(1, "b2b_special");
        step();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_done_pulse: got %b expected 0", done);
        end
    endtask

    task automatic test_reset_mid_op();
        int extra;
        logic [N-1:0] junk;
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        for (int i = 1; i < 10; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        junk = exp_q.pop_back();
        prev_res = '0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
            failures++;
            $display("FAIL midreset_state: got busy=%b done=%b result=%h expected 0 0 0", busy, done, result);
        end
        extra = 0;
        for (int i = 0; i < N + 4; i++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL midreset_stale: got %0d active cycles expected 0 (discarded %h)", extra, junk);
        end
        run_op(3'd7, 32'd100, 32'd7, 32'd2, "midreset_fresh");
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
